// File: rtl/button_req_capture.sv
// Four-button front end: synchronise, debounce, latch presses as pending requests,
// and offer them one at a time (bit 3 highest) over a valid/ready handshake.
module button_req_capture #(
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       req_ready,
  output logic [3:0] req_onehot,
  output logic       req_valid,
  output logic [3:0] pending,
  output logic       overrun
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic {IDLE, OFFER} state_t;

  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;
  logic [3:0] deb_level;
  logic [3:0] rise;
  logic [3:0] pending_reg;
  logic [3:0] pending_next;
  logic [3:0] clr;
  logic       overrun_reg;
  logic       overrun_next;
  logic [3:0] top_pick;
  logic [3:0] req_onehot_reg;
  logic       req_valid_reg;
  state_t     state_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_deb
      logic [DEB_W-1:0] cnt_reg;
      logic             deb_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
          deb_reg <= 1'b0;
        end else if (sync2_reg[gi] == deb_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          deb_reg <= sync2_reg[gi];
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + DEB_W'(1);
        end
      end

      assign deb_level[gi] = deb_reg;
      // True on exactly the edge where the debounced level flips 0->1.
      assign rise[gi] = ~deb_reg & sync2_reg[gi] & (cnt_reg == CNT_LAST);
    end
  endgenerate

  always_comb begin
    clr          = (state_reg == OFFER && req_ready) ? req_onehot_reg : 4'b0000;
    // A press landing on its own acceptance edge keeps the bit set and is not an overrun.
    pending_next = (pending_reg & ~clr) | rise;
    overrun_next = |(rise & pending_reg & ~clr);
  end

  always_comb begin
    top_pick = 4'b0000;
    if (pending_reg[3])      top_pick = 4'b1000;
    else if (pending_reg[2]) top_pick = 4'b0100;
    else if (pending_reg[1]) top_pick = 4'b0010;
    else if (pending_reg[0]) top_pick = 4'b0001;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= '0;
      overrun_reg <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      req_onehot_reg <= '0;
      req_valid_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pending_reg != 4'b0000) begin
            req_onehot_reg <= top_pick;
            req_valid_reg  <= 1'b1;
            state_reg      <= OFFER;
          end
        end
        OFFER: begin
          if (req_ready) begin
            req_onehot_reg <= '0;
            req_valid_reg  <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: begin
          req_onehot_reg <= '0;
          req_valid_reg  <= 1'b0;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

  assign req_onehot = req_onehot_reg;
  assign req_valid  = req_valid_reg;
  assign pending    = pending_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_button_req_capture.sv
// Directed bench for button_req_capture: a per-cycle vector table for a single press,
// plus hand-written sequences for glitch, priority, overrun, set-wins and async reset.
module tb_button_req_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic       req_ready = 1'b0;
  logic [3:0] req_onehot;
  logic       req_valid;
  logic [3:0] pending;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  button_req_capture #(.DEB_CYCLES(4), .DEB_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .req_ready (req_ready),
    .req_onehot(req_onehot),
    .req_valid (req_valid),
    .pending   (pending),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic       ready;
    logic       valid;
    logic [3:0] onehot;
    logic [3:0] pend;
    logic       ovr;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn       = 4'b0000;
    req_ready = 1'b0;
    rst       = 1'b1;
    #2;
    chk("rst_valid",   {7'd0, req_valid}, 8'd0);
    chk("rst_onehot",  {4'd0, req_onehot}, 8'd0);
    chk("rst_pending", {4'd0, pending}, 8'd0);
    chk("rst_overrun", {7'd0, overrun}, 8'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int ovr_cnt;
    int val_cnt;

    // Single press table: inputs applied before edge Ek, outputs checked after Ek.
    for (int i = 0; i < 18; i++) begin
      vecs[i].btn    = (i < 10) ? 4'b0100 : 4'b0000;
      vecs[i].ready  = 1'b1;
      vecs[i].valid  = 1'b0;
      vecs[i].onehot = 4'b0000;
      vecs[i].pend   = 4'b0000;
      vecs[i].ovr    = 1'b0;
    end
    vecs[5].pend   = 4'b0100;
    vecs[6].pend   = 4'b0100;
    vecs[6].valid  = 1'b1;
    vecs[6].onehot = 4'b0100;

    #1;
    do_reset();

    // 1. single press
    for (int i = 0; i < 18; i++) begin
      btn       = vecs[i].btn;
      req_ready = vecs[i].ready;
      tick();
      $display("vec %0d: btn=%b rdy=%b -> valid=%b onehot=%b pend=%b ovr=%b",
               i, btn, req_ready, req_valid, req_onehot, pending, overrun);
      chk($sformatf("t1_valid[%0d]", i),  {7'd0, req_valid},  {7'd0, vecs[i].valid});
      chk($sformatf("t1_onehot[%0d]", i), {4'd0, req_onehot}, {4'd0, vecs[i].onehot});
      chk($sformatf("t1_pend[%0d]", i),   {4'd0, pending},    {4'd0, vecs[i].pend});
      chk($sformatf("t1_ovr[%0d]", i),    {7'd0, overrun},    {7'd0, vecs[i].ovr});
    end

    // 2. glitch of three synchronised samples is rejected
    do_reset();
    btn = 4'b0010;
    repeat (3) tick();
    btn = 4'b0000;
    val_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (req_valid || pending != 4'b0000) val_cnt++;
    end
    $display("glitch: activity cycles=%0d", val_cnt);
    chk("t2_no_activity", val_cnt[7:0], 8'd0);

    // 3. priority: bit 3 offered first, then bit 0 after a bubble
    do_reset();
    btn = 4'b1001;
    repeat (7) tick();
    chk("t3_valid1",  {7'd0, req_valid}, 8'd1);
    chk("t3_onehot1", {4'd0, req_onehot}, 8'b1000);
    chk("t3_pend1",   {4'd0, pending}, 8'b1001);
    repeat (3) begin
      tick();
      chk("t3_hold", {3'd0, req_valid, req_onehot}, 8'b0001_1000);
    end
    req_ready = 1'b1;
    tick();
    $display("priority: accept -> valid=%b pend=%b", req_valid, pending);
    chk("t3_bubble_valid",  {7'd0, req_valid}, 8'd0);
    chk("t3_bubble_onehot", {4'd0, req_onehot}, 8'd0);
    chk("t3_bubble_pend",   {4'd0, pending}, 8'b0001);
    tick();
    chk("t3_valid2",  {7'd0, req_valid}, 8'd1);
    chk("t3_onehot2", {4'd0, req_onehot}, 8'b0001);
    tick();
    chk("t3_done_pend",  {4'd0, pending}, 8'd0);
    chk("t3_done_valid", {7'd0, req_valid}, 8'd0);

    // 4. overrun: second press while first is still pending
    do_reset();
    btn = 4'b0100;
    repeat (7) tick();
    chk("t4_offer", {3'd0, req_valid, req_onehot}, 8'b0001_0100);
    btn = 4'b0000;
    repeat (6) tick();
    btn = 4'b0100;
    ovr_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (overrun) ovr_cnt++;
      chk("t4_hold", {3'd0, req_valid, req_onehot}, 8'b0001_0100);
    end
    $display("overrun: pulses=%0d pend=%b", ovr_cnt, pending);
    chk("t4_ovr_count", ovr_cnt[7:0], 8'd1);
    chk("t4_pend", {4'd0, pending}, 8'b0100);
    req_ready = 1'b1;
    tick();
    chk("t4_accept_pend", {4'd0, pending}, 8'd0);
    val_cnt = 0;
    repeat (10) begin
      tick();
      if (req_valid) val_cnt++;
    end
    chk("t4_single_offer", val_cnt[7:0], 8'd0);

    // 5. set wins: deb rises on the acceptance edge
    do_reset();
    btn = 4'b0010;
    repeat (7) tick();
    chk("t5_offer", {3'd0, req_valid, req_onehot}, 8'b0001_0010);
    ovr_cnt = 0;
    btn = 4'b0000;
    repeat (6) begin tick(); if (overrun) ovr_cnt++; end
    btn = 4'b0010;
    repeat (5) begin tick(); if (overrun) ovr_cnt++; end
    chk("t5_pre_accept_valid", {7'd0, req_valid}, 8'd1);
    req_ready = 1'b1;
    tick();
    if (overrun) ovr_cnt++;
    $display("set-wins: accept -> valid=%b pend=%b ovr=%b", req_valid, pending, overrun);
    chk("t5_pend_kept", {4'd0, pending}, 8'b0010);
    chk("t5_valid_drop", {7'd0, req_valid}, 8'd0);
    tick();
    if (overrun) ovr_cnt++;
    chk("t5_offer2", {3'd0, req_valid, req_onehot}, 8'b0001_0010);
    tick();
    if (overrun) ovr_cnt++;
    chk("t5_final_pend", {4'd0, pending}, 8'd0);
    chk("t5_no_overrun", ovr_cnt[7:0], 8'd0);

    // 6. asynchronous reset in the middle of an offer
    do_reset();
    btn = 4'b0001;
    repeat (7) tick();
    chk("t6_offer", {3'd0, req_valid, req_onehot}, 8'b0001_0001);
    chk("t6_pend",  {4'd0, pending}, 8'b0001);
    rst = 1'b1;
    #1;
    $display("async reset: valid=%b onehot=%b pend=%b", req_valid, req_onehot, pending);
    chk("t6_valid",   {7'd0, req_valid}, 8'd0);
    chk("t6_onehot",  {4'd0, req_onehot}, 8'd0);
    chk("t6_pending", {4'd0, pending}, 8'd0);
    btn = 4'b0000;
    #1;
    rst = 1'b0;
    val_cnt = 0;
    repeat (8) begin
      tick();
      if (req_valid || pending != 4'b0000) val_cnt++;
    end
    chk("t6_quiet_after", val_cnt[7:0], 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
